// File: rtl/mips_defs.sv
// Shared MIPS datapath definitions: multiply/divide opcodes and the mul/div FSM states.
package mips_defs;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the mul/div datapath on {acc, shreg}: LSB-first shift-add for
// multiply, restoring trial subtract producing one quotient bit for divide.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] shreg_nxt
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] shifted;
    logic             fits;

    always_comb begin
        sum       = {1'b0, acc} + {1'b0, operand};
        partial   = {acc, shreg[WIDTH-1]};
        shifted   = {acc[WIDTH-2:0], shreg[WIDTH-1]};
        fits      = partial >= {1'b0, operand};
        acc_nxt   = acc;
        shreg_nxt = shreg;
        if (is_div) begin
            // remainder < divisor, so the difference always fits in WIDTH bits
            acc_nxt   = fits ? (shifted - operand) : shifted;
            shreg_nxt = {shreg[WIDTH-2:0], fits};
        end else if (shreg[0]) begin
            acc_nxt   = sum[WIDTH:1];
            shreg_nxt = {sum[0], shreg[WIDTH-1:1]};
        end else begin
            acc_nxt   = {1'b0, acc[WIDTH-1:1]};
            shreg_nxt = {acc[0], shreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: one bit per cycle over
// magnitudes, sign fix-up in a final cycle, start/busy/done handshake, flush and MTHI/MTLO.
module mul_div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc, shreg, divisor, a_raw;
    logic               div_op, neg_res, neg_rem, div_zero;
    logic [WIDTH-1:0]   acc_nxt, shreg_nxt;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic               accept, run_last;

    assign busy     = (state != S_IDLE);
    assign accept   = (state == S_IDLE) && start && !flush;
    assign run_last = (cnt == CNT_W'(WIDTH - 1));
    assign a_mag    = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
    assign b_mag    = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (div_op),
        .acc       (acc),
        .shreg     (shreg),
        .operand   (divisor),
        .acc_nxt   (acc_nxt),
        .shreg_nxt (shreg_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN: begin
                if (flush)         state_nxt = S_IDLE;
                else if (run_last) state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sign fix-up; MIN / -1 needs no special case since negating MIN wraps back to MIN.
    always_comb begin
        prod     = {acc, shreg};
        prod_fix = neg_res ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (div_op) begin
            if (div_zero) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -acc : acc;
                res_lo = neg_res ? -shreg : shreg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            shreg    <= '0;
            divisor  <= '0;
            a_raw    <= '0;
            div_op   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= (state == S_FIX) && !flush;
            if (accept) begin
                cnt      <= '0;
                acc      <= '0;
                shreg    <= a_mag;
                divisor  <= b_mag;
                a_raw    <= a;
                div_op   <= op_is_div(op);
                neg_res  <= op_is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem  <= op_is_signed(op) && a[WIDTH-1];
                div_zero <= op_is_div(op) && (b == '0);
            end else if ((state == S_RUN) && !flush) begin
                cnt   <= cnt + CNT_W'(1);
                acc   <= acc_nxt;
                shreg <= shreg_nxt;
            end
            if ((state == S_FIX) && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (!busy && !start) begin
                if (hi_we) hi <= wd;
                if (lo_we) lo <= wd;
            end
        end
    end

endmodule
